// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage and the hazard/control unit
// that steers it: reset defaults, next-PC select codes and IF/ID register controls.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES_DEFAULT = 400;

    typedef enum logic [1:0] {
        PCSEL_SEQ  = 2'd0,
        PCSEL_BR   = 2'd1,
        PCSEL_JMP  = 2'd2,
        PCSEL_HOLD = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_HOLD   = 2'd2
    } ifid_ctl_e;

    // A PC is unusable if it is not word aligned or its word runs past the memory end.
    function automatic logic pc_is_bad(input logic [31:0] pc, input logic [31:0] last_word);
        return (pc[1:0] != 2'b00) || (pc > last_word);
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: loads a fetched word with its PC+4, inserts a bubble
// (pc4 kept), or holds its contents.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  ifid_ctl_e   ctl,
    input  logic [31:0] fetched_instr,
    input  logic [31:0] fetched_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, matching real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= NOP_WORD;
            pc4   <= 32'h0000_0000;
            valid <= 1'b0;
        end else begin
            case (ctl)
                IFID_LOAD: begin
                    instr <= fetched_instr;
                    pc4   <= fetched_pc4;
                    valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    instr <= NOP_WORD;
                    valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, presents it to instruction memory, and
// registers the returned word into IF/ID with redirect, stall, flush and fault handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEFAULT,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT,
    parameter logic [31:0] CNT_RESET  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        jmp_take,
    input  logic [31:0] jmp_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_cnt,
    output logic        fault
);

    localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] cnt_q;
    logic        fault_q;
    logic        fault_set;
    logic        cnt_inc;
    logic        pc_bad;
    pc_sel_e     pc_sel;
    ifid_ctl_e   ifid_ctl;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_bad    = pc_is_bad(pc_q, LAST_WORD);
    assign imem_addr = pc_q;
    assign fetch_cnt = cnt_q;
    assign fault     = fault_q;

    // A latched fault outranks redirects; a fresh fault only loses to a redirect.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        pc_sel    = PCSEL_SEQ;
        ifid_ctl  = IFID_LOAD;
        cnt_inc   = 1'b0;
        fault_set = 1'b0;
        if (fault_q) begin
            pc_sel   = PCSEL_HOLD;
            ifid_ctl = IFID_BUBBLE;
        end else if (jmp_take) begin
            pc_sel   = PCSEL_JMP;
            ifid_ctl = IFID_BUBBLE;
        end else if (br_take) begin
            pc_sel   = PCSEL_BR;
            ifid_ctl = IFID_BUBBLE;
        end else if (pc_bad) begin
            pc_sel    = PCSEL_HOLD;
            ifid_ctl  = IFID_BUBBLE;
            fault_set = 1'b1;
        end else if (stall) begin
            pc_sel   = PCSEL_HOLD;
            ifid_ctl = flush ? IFID_BUBBLE : IFID_HOLD;
        end else if (flush) begin
            pc_sel   = PCSEL_SEQ;
            ifid_ctl = IFID_BUBBLE;
        end else begin
            pc_sel   = PCSEL_SEQ;
            ifid_ctl = IFID_LOAD;
            cnt_inc  = 1'b1;
        end
    end

    always_comb begin
        pc_next = pc_plus4;
        case (pc_sel)
            PCSEL_SEQ:  pc_next = pc_plus4;
            PCSEL_BR:   pc_next = br_target;
            PCSEL_JMP:  pc_next = jmp_target;
            PCSEL_HOLD: pc_next = pc_q;
            default:    pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            cnt_q   <= CNT_RESET;
            fault_q <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (cnt_inc) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
        end
    end

    if_id_reg #(
        .NOP_WORD(NOP_WORD)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .ctl          (ifid_ctl),
        .fetched_instr(imem_data),
        .fetched_pc4  (pc_plus4),
        .instr        (ifid_instr),
        .pc4          (ifid_pc4),
        .valid        (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory word at byte address a reads 0x1000_0000 + a.
// A second instance with a near-max counter start checks fetch_cnt wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br_take;
    logic [31:0] br_target;
    logic        jmp_take;
    logic [31:0] jmp_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_cnt;
    logic        fault;

    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic [31:0] w_ifid_instr;
    logic [31:0] w_ifid_pc4;
    logic        w_ifid_valid;
    logic [31:0] w_fetch_cnt;
    logic        w_fault;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr < 32'd400) return 32'h1000_0000 + {addr[31:2], 2'b00};
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_data   = mem_word(imem_addr);
    assign w_imem_data = mem_word(w_imem_addr);

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .br_take(br_take), .br_target(br_target),
        .jmp_take(jmp_take), .jmp_target(jmp_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .fetch_cnt(fetch_cnt), .fault(fault)
    );

    fetch_unit #(.CNT_RESET(32'hFFFF_FFFE)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .br_take(br_take), .br_target(br_target),
        .jmp_take(jmp_take), .jmp_target(jmp_target),
        .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .ifid_instr(w_ifid_instr), .ifid_pc4(w_ifid_pc4), .ifid_valid(w_ifid_valid),
        .fetch_cnt(w_fetch_cnt), .fault(w_fault)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One rising edge; results are sampled on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        br_take = 1'b0; br_target = 32'h0;
        jmp_take = 1'b0; jmp_target = 32'h0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_pc4", ifid_pc4, 32'h0);
        check("rst_valid", {31'b0, ifid_valid}, 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("wrap_rst_cnt", w_fetch_cnt, 32'hFFFF_FFFE);

        // Sequential fetch
        rst = 1'b0;
        check("seq0_addr", imem_addr, 32'h0);
        step();
        check("seq1_addr", imem_addr, 32'h4);
        check("seq1_instr", ifid_instr, 32'h1000_0000);
        check("seq1_pc4", ifid_pc4, 32'h4);
        check("seq1_valid", {31'b0, ifid_valid}, 32'd1);
        check("wrap_cnt1", w_fetch_cnt, 32'hFFFF_FFFF);
        step();
        check("seq2_addr", imem_addr, 32'h8);
        check("seq2_instr", ifid_instr, 32'h1000_0004);
        check("seq2_pc4", ifid_pc4, 32'h8);
        check("wrap_cnt2", w_fetch_cnt, 32'h0);

        // Stall for two edges at PC=8
        stall = 1'b1;
        step();
        step();
        check("stall_addr", imem_addr, 32'h8);
        check("stall_instr", ifid_instr, 32'h1000_0004);
        check("stall_pc4", ifid_pc4, 32'h8);
        check("stall_cnt", fetch_cnt, 32'd2);
        stall = 1'b0;
        step();
        check("resume_instr", ifid_instr, 32'h1000_0008);
        check("resume_pc4", ifid_pc4, 32'hC);
        check("resume_addr", imem_addr, 32'hC);
        check("resume_cnt", fetch_cnt, 32'd3);

        // Branch at PC=12
        br_take = 1'b1; br_target = 32'h40;
        step();
        idle();
        check("br_addr", imem_addr, 32'h40);
        check("br_valid", {31'b0, ifid_valid}, 32'd0);
        check("br_instr", ifid_instr, 32'h0);
        check("br_pc4", ifid_pc4, 32'hC);
        check("br_cnt", fetch_cnt, 32'd3);
        step();
        check("br_tgt_instr", ifid_instr, 32'h1000_0040);
        check("br_tgt_pc4", ifid_pc4, 32'h44);
        check("br_tgt_cnt", fetch_cnt, 32'd4);

        // Jump and branch together: jump wins
        jmp_take = 1'b1; jmp_target = 32'h80;
        br_take = 1'b1; br_target = 32'h40;
        step();
        idle();
        check("jb_addr", imem_addr, 32'h80);
        check("jb_valid", {31'b0, ifid_valid}, 32'd0);
        step();
        check("jb_tgt_instr", ifid_instr, 32'h1000_0080);
        check("jb_tgt_pc4", ifid_pc4, 32'h84);

        // Flush alone: bubble, PC advances
        flush = 1'b1;
        step();
        idle();
        check("fl_addr", imem_addr, 32'h88);
        check("fl_valid", {31'b0, ifid_valid}, 32'd0);
        check("fl_instr", ifid_instr, 32'h0);
        check("fl_pc4", ifid_pc4, 32'h84);
        check("fl_cnt", fetch_cnt, 32'd5);
        step();
        check("post_fl_instr", ifid_instr, 32'h1000_0088);

        // Stall + flush: PC holds, IF/ID bubbles
        stall = 1'b1; flush = 1'b1;
        step();
        idle();
        check("sf_addr", imem_addr, 32'h8C);
        check("sf_valid", {31'b0, ifid_valid}, 32'd0);
        check("sf_instr", ifid_instr, 32'h0);
        check("sf_cnt", fetch_cnt, 32'd6);

        // Redirect overrides stall
        stall = 1'b1; br_take = 1'b1; br_target = 32'h10;
        step();
        idle();
        check("brst_addr", imem_addr, 32'h10);
        step();
        check("brst_instr", ifid_instr, 32'h1000_0010);
        check("brst_cnt", fetch_cnt, 32'd7);

        // Jump past end of memory: fault one edge later, PC frozen
        jmp_take = 1'b1; jmp_target = 32'h190;
        step();
        idle();
        check("oor_addr", imem_addr, 32'h190);
        check("oor_fault0", {31'b0, fault}, 32'd0);
        step();
        check("oor_fault1", {31'b0, fault}, 32'd1);
        check("oor_hold", imem_addr, 32'h190);
        check("oor_valid", {31'b0, ifid_valid}, 32'd0);
        br_take = 1'b1; br_target = 32'h20;
        step();
        idle();
        check("oor_br_ign", imem_addr, 32'h190);
        check("oor_sticky", {31'b0, fault}, 32'd1);
        check("oor_cnt", fetch_cnt, 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("clr_addr", imem_addr, 32'h0);
        check("clr_fault", {31'b0, fault}, 32'd0);
        check("clr_cnt", fetch_cnt, 32'd0);

        // Last legal word is fetched, next PC faults
        jmp_take = 1'b1; jmp_target = 32'h18C;
        step();
        idle();
        step();
        check("last_instr", ifid_instr, 32'h1000_018C);
        check("last_fault", {31'b0, fault}, 32'd0);
        check("last_addr", imem_addr, 32'h190);
        step();
        check("edge_fault", {31'b0, fault}, 32'd1);

        // Misaligned jump
        rst = 1'b1;
        step();
        rst = 1'b0;
        jmp_take = 1'b1; jmp_target = 32'h6;
        step();
        idle();
        check("mis_addr", imem_addr, 32'h6);
        check("mis_fault0", {31'b0, fault}, 32'd0);
        step();
        check("mis_fault1", {31'b0, fault}, 32'd1);
        check("mis_hold", imem_addr, 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
